// File: rtl/llsc_ctrl_if.sv
// Bus bundle for the LL/SC link controller.
// master: pipeline/memory side; drives flush, eret, LL/SC/snoop requests and mem_ack,
//         and observes mem_req, sc_done, sc_result, stall_req, LLbit_o, link_addr_o.
// slave:  the llsc_ctrl block itself.
interface llsc_ctrl_if;
    logic        flush;
    logic        flush_cause;
    logic        eret;
    logic        ll_valid;
    logic [31:0] ll_addr;
    logic        sc_valid;
    logic [31:0] sc_addr;
    logic        snoop_valid;
    logic [31:0] snoop_addr;
    logic        mem_ack;
    logic        mem_req;
    logic        sc_done;
    logic        sc_result;
    logic        stall_req;
    logic        LLbit_o;
    logic [31:0] link_addr_o;

    modport master (
        output flush, flush_cause, eret, ll_valid, ll_addr, sc_valid, sc_addr,
               snoop_valid, snoop_addr, mem_ack,
        input  mem_req, sc_done, sc_result, stall_req, LLbit_o, link_addr_o
    );

    modport slave (
        input  flush, flush_cause, eret, ll_valid, ll_addr, sc_valid, sc_addr,
               snoop_valid, snoop_addr, mem_ack,
        output mem_req, sc_done, sc_result, stall_req, LLbit_o, link_addr_o
    );
endinterface

// File: rtl/llsc_ctrl.sv
// Load-linked / store-conditional link controller.
// Tracks one linked address (granule of 2**GRAN_BITS bytes), clears the link on
// exception flush, ERET, matching snoop or timeout, and sequences the SC memory write.
// Ports:
//   clk, rst  - clock and asynchronous active-high reset
//   bus       - llsc_ctrl_if.slave: flush/eret/LL/SC/snoop/mem_ack in;
//               mem_req, sc_done, sc_result, stall_req, LLbit_o, link_addr_o out
module llsc_ctrl #(
    parameter int unsigned LINK_TIMEOUT = 4096,
    parameter int unsigned GRAN_BITS    = 2
) (
    input logic        clk,
    input logic        rst,
    llsc_ctrl_if.slave bus
);
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_LINKED   = 2'd1;
    localparam logic [1:0] ST_SC_WAIT  = 2'd2;
    localparam logic [1:0] ST_SC_DRAIN = 2'd3;

    localparam logic [31:0] GRAN_MASK = ~((32'd1 << GRAN_BITS) - 32'd1);
    localparam logic [15:0] CNT_LAST  = 16'(LINK_TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] link_addr_q, link_addr_d;
    logic        sc_done_q, sc_done_d;
    logic        sc_result_q, sc_result_d;

    logic exc_flush;
    logic snoop_hit;
    logic sc_hit;

    assign exc_flush = bus.flush & bus.flush_cause;
    // link_addr_q is always stored with the granule bits cleared.
    assign snoop_hit = bus.snoop_valid && ((bus.snoop_addr & GRAN_MASK) == link_addr_q);
    assign sc_hit    = ((bus.sc_addr & GRAN_MASK) == link_addr_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        link_addr_d = link_addr_q;
        sc_done_d   = 1'b0;
        sc_result_d = 1'b0;
        case (state_q)
            ST_IDLE, ST_LINKED: begin
                cnt_d = 16'd0;
                if (exc_flush || bus.eret) begin
                    state_d = ST_IDLE;
                end else if (state_q == ST_LINKED && snoop_hit) begin
                    state_d = ST_IDLE;
                end else if (bus.ll_valid) begin
                    state_d     = ST_LINKED;
                    link_addr_d = bus.ll_addr & GRAN_MASK;
                end else if (bus.sc_valid) begin
                    if (state_q == ST_LINKED && sc_hit) begin
                        state_d = ST_SC_WAIT;
                    end else begin
                        // Failed SC: report immediately, no memory write.
                        state_d   = ST_IDLE;
                        sc_done_d = 1'b1;
                    end
                end else if (state_q == ST_LINKED) begin
                    if (cnt_q >= CNT_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            ST_SC_WAIT: begin
                if (exc_flush) begin
                    // The write cannot be retracted; wait for its ack silently.
                    state_d = bus.mem_ack ? ST_IDLE : ST_SC_DRAIN;
                end else if (bus.mem_ack) begin
                    state_d     = ST_IDLE;
                    sc_done_d   = 1'b1;
                    sc_result_d = 1'b1;
                end
            end
            default: begin
                if (bus.mem_ack) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 16'd0;
            link_addr_q <= 32'd0;
            sc_done_q   <= 1'b0;
            sc_result_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            link_addr_q <= link_addr_d;
            sc_done_q   <= sc_done_d;
            sc_result_q <= sc_result_d;
        end
    end

    assign bus.mem_req     = (state_q == ST_SC_WAIT) || (state_q == ST_SC_DRAIN);
    // While draining an aborted write, new LL/SC must wait for the bus to free up.
    assign bus.stall_req   = (state_q == ST_SC_WAIT) ||
                             ((state_q == ST_SC_DRAIN) && (bus.ll_valid || bus.sc_valid));
    assign bus.LLbit_o     = (state_q == ST_LINKED) || (state_q == ST_SC_WAIT);
    assign bus.link_addr_o = link_addr_q;
    assign bus.sc_done     = sc_done_q;
    assign bus.sc_result   = sc_result_q;
endmodule

// File: tb/tb_llsc_ctrl.sv
module tb_llsc_ctrl;
    localparam int unsigned LT = 8;
    localparam int unsigned GB = 2;
    localparam logic [31:0] MASK = ~((32'd1 << GB) - 32'd1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    llsc_ctrl_if bus();

    llsc_ctrl #(.LINK_TIMEOUT(LT), .GRAN_BITS(GB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: a link flag with its granule address and birth cycle,
    // plus an outstanding-write flag that may be marked aborted.
    bit          m_link;
    logic [31:0] m_addr;
    int          m_born;
    bit          m_wr;
    bit          m_abort;
    bit          m_done;
    bit          m_res;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_link = 0; m_addr = 32'd0; m_born = 0;
        m_wr = 0; m_abort = 0; m_done = 0; m_res = 0;
    endtask

    function automatic bit same_gran(input logic [31:0] a);
        return (a & MASK) == m_addr;
    endfunction

    task automatic model_edge();
        bit exc;
        exc = bus.flush && bus.flush_cause;
        m_done = 0;
        m_res  = 0;
        if (m_wr) begin
            if (!m_abort && exc) begin
                m_abort = 1;
                m_link  = 0;
            end else if (!m_abort && bus.mem_ack) begin
                m_link = 0;
                m_done = 1;
                m_res  = 1;
            end
            if (bus.mem_ack) begin
                m_wr    = 0;
                m_abort = 0;
            end
        end else if (exc || bus.eret) begin
            m_link = 0;
        end else if (m_link && bus.snoop_valid && same_gran(bus.snoop_addr)) begin
            m_link = 0;
        end else if (bus.ll_valid) begin
            m_link = 1;
            m_addr = bus.ll_addr & MASK;
            m_born = cyc;
        end else if (bus.sc_valid) begin
            if (m_link && same_gran(bus.sc_addr)) begin
                m_wr = 1;
            end else begin
                m_link = 0;
                m_done = 1;
            end
        end else if (m_link && (cyc - m_born) >= int'(LT)) begin
            m_link = 0;
        end
    endtask

    task automatic check_outs();
        chk("mem_req",   bus.mem_req,   m_wr);
        chk("stall_req", bus.stall_req,
            m_wr && (!m_abort || bus.ll_valid || bus.sc_valid));
        chk("LLbit",     bus.LLbit_o,   m_link);
        chk("link_addr", bus.link_addr_o, m_addr);
        chk("sc_done",   bus.sc_done,   m_done);
        chk("sc_result", bus.sc_result, m_res);
    endtask

    task automatic tick();
        @(negedge clk);
        check_outs();
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge();
        cyc++;
        #1;
    endtask

    task automatic clr();
        bus.flush = 0; bus.flush_cause = 0; bus.eret = 0;
        bus.ll_valid = 0; bus.ll_addr = 32'd0;
        bus.sc_valid = 0; bus.sc_addr = 32'd0;
        bus.snoop_valid = 0; bus.snoop_addr = 32'd0;
        bus.mem_ack = 0;
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] b;
        b = 32'h1000 * (($urandom % 3) + 1);
        return b + ($urandom % 8);
    endfunction

    initial begin
        clr();
        model_reset();
        repeat (2) tick();
        rst = 0;

        // LL/SC success with ack on the third write cycle
        clr(); bus.ll_valid = 1; bus.ll_addr = 32'h1000; tick();
        clr(); bus.sc_valid = 1; bus.sc_addr = 32'h1000; tick();
        clr(); tick(); tick();
        bus.mem_ack = 1; tick();
        clr();
        chk("d037_done", bus.sc_done, 1);
        chk("d037_res", bus.sc_result, 1);
        chk("d037_llbit", bus.LLbit_o, 0);
        tick();

        // Snoop in the same granule kills the link
        clr(); bus.ll_valid = 1; bus.ll_addr = 32'h1000; tick();
        clr(); bus.snoop_valid = 1; bus.snoop_addr = 32'h1002; tick();
        clr(); bus.sc_valid = 1; bus.sc_addr = 32'h1000; tick();
        clr();
        chk("d038_req", bus.mem_req, 0);
        chk("d038_done", bus.sc_done, 1);
        chk("d038_res", bus.sc_result, 0);
        tick();

        // Exception flush while the SC write is outstanding
        clr(); bus.ll_valid = 1; bus.ll_addr = 32'h2000; tick();
        clr(); bus.sc_valid = 1; bus.sc_addr = 32'h2000; tick();
        clr(); bus.flush = 1; bus.flush_cause = 1; tick();
        clr();
        chk("d039_drain_req", bus.mem_req, 1);
        chk("d039_drain_stall", bus.stall_req, 0);
        tick();
        bus.mem_ack = 1; tick();
        clr();
        chk("d039_req", bus.mem_req, 0);
        chk("d039_done", bus.sc_done, 0);
        chk("d039_llbit", bus.LLbit_o, 0);
        tick();

        // Link timeout after LT quiet cycles
        clr(); bus.ll_valid = 1; bus.ll_addr = 32'h3000; tick();
        clr(); repeat (LT - 1) tick();
        chk("d040_alive", bus.LLbit_o, 1);
        tick();
        chk("d040_expired", bus.LLbit_o, 0);
        bus.sc_valid = 1; bus.sc_addr = 32'h3000; tick();
        clr();
        chk("d040_done", bus.sc_done, 1);
        chk("d040_res", bus.sc_result, 0);

        // LL racing a flush
        bus.ll_valid = 1; bus.ll_addr = 32'h4000; bus.flush = 1; bus.flush_cause = 1; tick();
        chk("d041_exc", bus.LLbit_o, 0);
        bus.flush_cause = 0; tick();
        clr();
        chk("d041_nonexc", bus.LLbit_o, 1);

        // Asynchronous reset in the middle of an SC write
        bus.sc_valid = 1; bus.sc_addr = 32'h4000; tick();
        clr();
        chk("d042_wait", bus.mem_req, 1);
        #2 rst = 1;
        model_reset();
        #1;
        check_outs();
        chk("d042_async_llbit", bus.LLbit_o, 0);
        tick();
        rst = 0;
        tick();
        bus.sc_valid = 1; bus.sc_addr = 32'h4000; tick();
        clr();
        chk("d042_sc_fail", bus.sc_result, 0);
        chk("d042_sc_done", bus.sc_done, 1);
        tick();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int dens;
            dens = (i < 1500) ? 6 : 16;
            clr();
            rst = (($urandom % 200) == 0);
            if (rst) model_reset();
            bus.ll_valid    = ($urandom % dens) == 0;
            bus.ll_addr     = pick();
            bus.sc_valid    = ($urandom % dens) == 0;
            bus.sc_addr     = pick();
            bus.snoop_valid = ($urandom % dens) == 0;
            bus.snoop_addr  = pick();
            bus.flush       = ($urandom % 12) == 0;
            bus.flush_cause = $urandom % 2;
            bus.eret        = ($urandom % 30) == 0;
            bus.mem_ack     = ($urandom % 3) == 0;
            tick();
        end
        rst = 0;
        clr();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
